// File: rtl/usr_shift_sequencer.sv
// Command sequencer for a 4-mode universal shift register: load or N-place shifts with capture.
// Define ROTATE_EN to add cmd_rot, which recirculates the outgoing bit instead of using fill bits.
module usr_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef ROTATE_EN
    input  logic             cmd_rot,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             s1,
    output logic             s0,
    output logic             r_in,
    output logic             l_in,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_LEFT  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem_q;
    logic [WIDTH-1:0] pos_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] eff_count;
    logic             accept;
    logic             skip;
    logic             cap_bit;
    logic             fill_bit;

    assign accept    = (state == IDLE) && cmd_valid;
    assign eff_count = (cmd_count > WIDTH_C) ? WIDTH_C : cmd_count;
    assign skip      = (cmd_op == OP_NOP) ||
                       ((cmd_op != OP_LOAD) && (eff_count == '0));
    assign cap_bit   = (op_q == OP_RIGHT) ? q[0] : q[WIDTH-1];
    assign rsp_data  = out_q;

`ifdef ROTATE_EN
    logic rot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rot_q <= 1'b0;
        else if (accept)
            rot_q <= cmd_rot;
    end

    // Rotation feeds the bit leaving the register straight back in.
    assign fill_bit = rot_q ? cap_bit : data_q[0];
`else
    assign fill_bit = data_q[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid)
                    state_nxt = skip ? RESP : EXEC;
            end
            EXEC: begin
                if ((op_q == OP_LOAD) || (rem_q == ONE_C))
                    state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pos_q is a one-hot pointer to the capture slot of the current shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_NOP;
            data_q <= '0;
            rem_q  <= '0;
            pos_q  <= '0;
            out_q  <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rem_q  <= eff_count;
            pos_q  <= WIDTH'(1);
            out_q  <= '0;
        end else if (state == EXEC) begin
            if (op_q == OP_LOAD) begin
                out_q <= q;
            end else begin
                out_q  <= out_q | (pos_q & {WIDTH{cap_bit}});
                pos_q  <= pos_q << 1;
                data_q <= data_q >> 1;
                rem_q  <= rem_q - ONE_C;
            end
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        s1        = 1'b0;
        s0        = 1'b0;
        r_in      = 1'b0;
        l_in      = 1'b0;
        b         = '0;
        unique case (state)
            IDLE: cmd_ready = 1'b1;
            EXEC: begin
                busy = 1'b1;
                s1   = op_q[1];
                s0   = op_q[0];
                r_in = (op_q == OP_RIGHT) && fill_bit;
                l_in = (op_q == OP_LEFT) && fill_bit;
                if (op_q == OP_LOAD)
                    b = data_q;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer with a behavioural 4-bit universal shift register on its selects.
// Expected responses go to a scoreboard queue; a monitor pops them on each response handshake.
module tb_usr_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_count = 3'd0;
    logic [3:0] cmd_data = 4'b0000;
`ifdef ROTATE_EN
    logic       cmd_rot = 1'b0;
`endif
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic       busy;
    logic       s1;
    logic       s0;
    logic       r_in;
    logic       l_in;
    logic [3:0] b;
    logic [3:0] q = 4'b0000;

    int         checks = 0;
    int         errors = 0;
    int         sel_cycles = 0;
    logic [3:0] last_b = 4'b0000;
    logic [3:0] sb[$];

    usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_count(cmd_count),
        .cmd_data(cmd_data),
`ifdef ROTATE_EN
        .cmd_rot(cmd_rot),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .busy(busy),
        .s1(s1),
        .s0(s0),
        .r_in(r_in),
        .l_in(l_in),
        .b(b),
        .q(q)
    );

    initial forever #5 clk = ~clk;

    // Universal shift register model; it has no reset.
    always_ff @(posedge clk) begin
        case ({s1, s0})
            2'b01:   q <= {r_in, q[3:1]};
            2'b10:   q <= {q[2:0], l_in};
            2'b11:   q <= b;
            default: q <= q;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (busy && i < 60);
        if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic rot, output logic ok);
        @(posedge clk);
        #1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
`ifdef ROTATE_EN
        cmd_rot   = rot;
`else
        if (rot) cmd_data = data;
`endif
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input string name, input logic [1:0] op, input logic [2:0] cnt,
                        input logic [3:0] data, input logic rot, input logic [3:0] exp_rsp,
                        input int exp_sel, input logic [3:0] exp_q);
        int   start;
        logic ok;
        start = sel_cycles;
        sb.push_back(exp_rsp);
        issue(op, cnt, data, rot, ok);
        if (!ok) chk({name, "_accept_timeout"}, 32'd1, 32'd0);
        wait_idle(name);
        #1;
        chk({name, "_sel_cycles"}, 32'(sel_cycles - start), 32'(exp_sel));
        chk({name, "_q"}, 32'(q), 32'(exp_q));
    endtask

    initial begin
        logic ok;
        int   start;
        int   n;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if ({s1, s0} != 2'b00) sel_cycles++;
                    if ({s1, s0} == 2'b11) last_b = b;
                    if (rsp_valid && rsp_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF);
                        end else begin
                            chk("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
                        end
                    end
                end
            end
        join_none

        // Reset asserted mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("rst_sel", 32'({s1, s0}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        send("load1010", 2'b11, 3'd0, 4'b1010, 1'b0, 4'b0000, 1, 4'b1010);
        chk("load_b", 32'(last_b), 32'hA);
        send("right2", 2'b01, 3'd2, 4'b0011, 1'b0, 4'b0010, 2, 4'b1110);
        send("reload", 2'b11, 3'd0, 4'b1010, 1'b0, 4'b1110, 1, 4'b1010);
        send("left3", 2'b10, 3'd3, 4'b0001, 1'b0, 4'b0101, 3, 4'b0100);
        send("count0", 2'b01, 3'd0, 4'b1111, 1'b0, 4'b0000, 0, 4'b0100);
        send("count7", 2'b01, 3'd7, 4'b1111, 1'b0, 4'b0100, 4, 4'b1111);
        send("nop", 2'b00, 3'd3, 4'b1111, 1'b0, 4'b0000, 0, 4'b1111);

        // Backpressure: response held, new command refused
        start = sel_cycles;
        rsp_ready = 1'b0;
        sb.push_back(4'b0001);
        issue(2'b01, 3'd1, 4'b0000, 1'b0, ok);
        if (!ok) chk("bp_accept_timeout", 32'd1, 32'd0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("bp_rsp_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        cmd_op    = 2'b11;
        cmd_data  = 4'b0000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h1);
            chk("bp_sel", 32'({s1, s0}), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp");
        #1;
        chk("bp_sel_cycles", 32'(sel_cycles - start), 32'd1);
        chk("bp_q", 32'(q), 32'h7);

        // Reset after the first of three right shifts
        send("load_pre_rst", 2'b11, 3'd0, 4'b1010, 1'b0, 4'b0111, 1, 4'b1010);
        @(posedge clk);
        #1;
        cmd_op    = 2'b01;
        cmd_count = 3'd3;
        cmd_data  = 4'b0000;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("mid_rst_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sel", 32'({s1, s0}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("mid_rst_q", 32'(q), 32'h5);
        chk("mid_rst_busy_after", 32'(busy), 32'd0);
        chk("mid_rst_no_rsp", 32'(sb.size()), 32'd0);

        // Rotate (when built in) versus zero fill
        send("load1001", 2'b11, 3'd0, 4'b1001, 1'b0, 4'b0101, 1, 4'b1001);
`ifdef ROTATE_EN
        send("rot_right1", 2'b01, 3'd1, 4'b0000, 1'b1, 4'b0001, 1, 4'b1100);
`else
        send("fill_right1", 2'b01, 3'd1, 4'b0000, 1'b0, 4'b0001, 1, 4'b0100);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
